// File: rtl/irq_controller.sv
// irq_controller: coprocessor-0 interrupt unit for the 5-stage MIPS core.
// Holds Status, Cause and EPC for N_IRQ channels. Each channel is level or
// rising-edge sensitive according to EDGE_MASK. The unit asks fetch to
// redirect to VECTOR and supplies the return PC for eret.
// Optional macro IRQ_SYNC_EN adds a 2-flop synchroniser ahead of the sample
// register. This makes the i_irq to pending latency 3 cycles instead of 1.
// o_state is a debug view of the FSM: 0 = RUN, 1 = HANDLER.
module irq_controller #(
    parameter int                N_IRQ     = 2,
    parameter int                PC_W      = 30,
    parameter logic [PC_W-1:0]   VECTOR    = 30'h34,
    parameter logic [N_IRQ-1:0]  EDGE_MASK = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_IRQ-1:0]  i_irq,
    input  logic              i_stall,
    input  logic [PC_W-1:0]   i_ret_pc,
    input  logic              i_epc_fix,
    input  logic              i_eret,
    input  logic              i_sw_we,
    input  logic [31:0]       i_sw_data,
    output logic              o_take,
    output logic [PC_W-1:0]   o_vector,
    output logic [PC_W-1:0]   o_epc,
    output logic [31:0]       o_status,
    output logic [31:0]       o_cause,
    output logic [N_IRQ-1:0]  o_pending,
    output logic              o_state
);

    typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

    state_t             state, state_next;
    logic [N_IRQ-1:0]   s_irq, s_irq_d;
    logic [N_IRQ-1:0]   edge_pend;
    logic [N_IRQ-1:0]   pending, elig, win_oh;
    logic               found;
    logic               ie;
    logic [N_IRQ-1:0]   im;
    logic [N_IRQ-1:0]   cause_ip;
    logic [PC_W-1:0]    epc;
    logic               take_d;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0]   sync_1, sync_2;

    // Two-flop synchroniser followed by the sample register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
            s_irq  <= '0;
        end else begin
            sync_1 <= i_irq;
            sync_2 <= sync_1;
            s_irq  <= sync_2;
        end
    end
`else
    // Single sample register for the raw requests.
    always_ff @(posedge Clk) begin
        if (Reset) s_irq <= '0;
        else       s_irq <= i_irq;
    end
`endif

    // Level channels follow s_irq directly. Edge channels use the latched bit.
    always_comb begin
        pending = (EDGE_MASK & edge_pend) | (~EDGE_MASK & s_irq);
        elig    = pending & im;
    end

    // Select the lowest-index eligible channel as a one-hot winner.
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (elig[i] && !found) begin
                win_oh[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Edge pending bits are held through stalls and cleared when the channel
    // wins a take. A new rising edge in the same cycle keeps the bit set.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s_irq_d   <= '0;
            edge_pend <= '0;
        end else begin
            s_irq_d   <= s_irq;
            edge_pend <= EDGE_MASK &
                         ((edge_pend & ~(o_take ? win_oh : '0)) | (s_irq & ~s_irq_d));
        end
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) state <= RUN;
        else       state <= state_next;
    end

    // o_take is a single-cycle request to fetch, with no handshake. Fetch
    // redirects on any cycle where it is high, and the take commits on that
    // same clock edge. Only RUN can take an interrupt. eret returns from
    // HANDLER to RUN.
    always_comb begin
        state_next = state;
        o_take     = 1'b0;
        case (state)
            RUN: begin
                o_take = ie & (|elig) & ~i_stall & ~i_eret;
                if (o_take) state_next = HANDLER;
            end
            HANDLER: begin
                if (i_eret) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Status, Cause and EPC update. A take forces IE to 0 and eret forces IE
    // to 1, overriding any IE bit written by mtc0 in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ie       <= 1'b0;
            im       <= '0;
            cause_ip <= '0;
            epc      <= '0;
            take_d   <= 1'b0;
        end else begin
            take_d <= o_take;
            if (i_sw_we) begin
                ie <= i_sw_data[0];
                im <= i_sw_data[8 +: N_IRQ];
            end
            if (o_take)      ie <= 1'b0;
            else if (i_eret) ie <= 1'b1;
            if (o_take) begin
                epc      <= i_ret_pc;
                cause_ip <= win_oh;
            end else if (take_d && i_epc_fix) begin
                epc <= i_ret_pc;
            end
        end
    end

    // Register views with undefined bits reading as zero.
    always_comb begin
        o_status              = '0;
        o_status[0]           = ie;
        o_status[8 +: N_IRQ]  = im;
        o_cause               = '0;
        o_cause[8 +: N_IRQ]   = cause_ip;
        o_vector              = VECTOR;
        o_epc                 = epc;
        o_pending             = pending;
        o_state               = (state == HANDLER);
    end

endmodule
